// File: rtl/frogger_game_flow_pkg.sv
// ---------------------------------------------------------------------------
// frogger_game_flow_pkg
//
// Shared definitions for the Frogger game-flow controller.
//
// Contents:
//   flow_state_t      - game-flow state encoding. Sprite_Display decodes
//                       these same values, so they must not be reordered.
//   LIVES_INI_DEFAULT - default number of lives at the start of a game.
//   LEVEL_MAX         - value at which the level counter stops counting.
//   level_inc_sat()   - level increment that holds at LEVEL_MAX.
// ---------------------------------------------------------------------------
package frogger_game_flow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_HIT       = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } flow_state_t;

    localparam int         LIVES_INI_DEFAULT = 3;
    localparam logic [3:0] LEVEL_MAX         = 4'd15;

    // The level display is a single hex digit, so the count must stop at
    // 15 instead of wrapping back to 0.
    function automatic logic [3:0] level_inc_sat(input logic [3:0] level);
        return (level == LEVEL_MAX) ? level : level + 4'd1;
    endfunction

endpackage

// File: rtl/frogger_game_flow_timer.sv
// ---------------------------------------------------------------------------
// frogger_game_flow_timer
//
// Loadable down-counter with a done flag and a blink toggle. The game-flow
// controller uses it to time the hit-recovery window and to flash the frog
// sprite during that window.
//
// Ports:
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   load       in  load load_value into the counter and start blinking
//                  with flash = 1
//   load_value in  initial count (C_COUNT_BITS wide)
//   run        in  count down and advance the blink phase this cycle
//   done       out counter is at zero
//   flash      out blink output; forced to 0 whenever the timer is idle
//
// Parameters:
//   C_COUNT_BITS   width of the down-counter
//   C_BLINK_CYCLES cycles per flash half-period (>= 1)
// ---------------------------------------------------------------------------
module frogger_game_flow_timer #(
    parameter int C_COUNT_BITS   = 25,
    parameter int C_BLINK_CYCLES = 3_125_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [C_COUNT_BITS-1:0] load_value,
    input  logic                    run,
    output logic                    done,
    output logic                    flash
);

    localparam int BLINK_BITS = $clog2(C_BLINK_CYCLES + 1);
    localparam logic [BLINK_BITS-1:0] BLINK_RELOAD = BLINK_BITS'(C_BLINK_CYCLES - 1);

    logic [C_COUNT_BITS-1:0] count;
    logic [BLINK_BITS-1:0]   blink_count;

    // A load starts a fresh window: the counter takes the load value and
    // the sprite starts visible for a full half-period. While running, the
    // main counter walks down to zero and holds there, and the blink
    // counter reloads every half-period so the flash toggles steadily.
    // When neither load nor run is asserted the timer parks at zero with
    // flash off, so flash is low everywhere outside the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            blink_count <= '0;
            flash       <= 1'b0;
        end else if (load) begin
            count       <= load_value;
            blink_count <= BLINK_RELOAD;
            flash       <= 1'b1;
        end else if (run) begin
            if (count != '0) begin
                count <= count - C_COUNT_BITS'(1);
            end
            if (blink_count == '0) begin
                blink_count <= BLINK_RELOAD;
                flash       <= ~flash;
            end else begin
                blink_count <= blink_count - BLINK_BITS'(1);
            end
        end else begin
            count       <= '0;
            blink_count <= '0;
            flash       <= 1'b0;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/frogger_game_flow.sv
// ---------------------------------------------------------------------------
// frogger_game_flow
//
// Lives-aware game-flow controller for Frogger. It sits between the
// Collisions / Character_Control pair and the rest of the datapath and
// sequences the game through idle, running, hit-recovery, game over and
// win.
//
// Ports:
//   i_Clk          in  system clock (25 MHz pixel clock)
//   i_Reset        in  synchronous, active-high reset
//   i_Start        in  debounced all-switches-pressed level
//   i_Has_Collided in  frog/car overlap level
//   i_Level_Up     in  one-cycle pulse when the frog reaches the top row
//   i_Score        in  current score (C_SCORE_BITS wide)
//   o_Game_Active  out high only while RUNNING
//   o_Frog_Reset   out one-cycle pulse: return the frog to its base position
//   o_Lives        out remaining lives
//   o_Level        out level counter, saturating at 15
//   o_State        out current state encoding (flow_state_t)
//   o_Flash        out frog-sprite blink enable during HIT
//   o_Game_Over    out high in GAME_OVER
//   o_Win          out high in WIN
//
// Every output is a register, so a qualifying input shows up on the
// outputs one clock after it is sampled.
// ---------------------------------------------------------------------------
module frogger_game_flow #(
    parameter int C_LIVES_INI    = frogger_game_flow_pkg::LIVES_INI_DEFAULT,
    parameter int C_HIT_CYCLES   = 25_000_000,
    parameter int C_BLINK_CYCLES = 3_125_000,
    parameter int C_WIN_SCORE    = 10,
    parameter int C_SCORE_BITS   = 6
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Start,
    input  logic                    i_Has_Collided,
    input  logic                    i_Level_Up,
    input  logic [C_SCORE_BITS-1:0] i_Score,
    output logic                    o_Game_Active,
    output logic                    o_Frog_Reset,
    output logic [1:0]              o_Lives,
    output logic [3:0]              o_Level,
    output logic [2:0]              o_State,
    output logic                    o_Flash,
    output logic                    o_Game_Over,
    output logic                    o_Win
);

    import frogger_game_flow_pkg::*;

    localparam int TIMER_BITS = (C_HIT_CYCLES > 2) ? $clog2(C_HIT_CYCLES) : 1;
    localparam logic [TIMER_BITS-1:0] HIT_LOAD   = TIMER_BITS'(C_HIT_CYCLES - 1);
    localparam logic [1:0]            LIVES_INI  = 2'(C_LIVES_INI);
    localparam logic [C_SCORE_BITS-1:0] WIN_SCORE = C_SCORE_BITS'(C_WIN_SCORE);

    flow_state_t state;
    flow_state_t next_state;

    logic [1:0] lives;
    logic [1:0] next_lives;
    logic [3:0] level;
    logic [3:0] next_level;
    logic       frog_reset;
    logic       next_frog_reset;
    logic       game_active;
    logic       game_over;
    logic       win;

    logic start_prev;
    logic start_event;
    logic timer_load;
    logic timer_run;
    logic timer_done;
    logic flash;

    // Only a rising edge of the start level begins a game. The previous
    // value comes out of reset as 1, so switches that were already held
    // down when reset was released do not count as a press.
    assign start_event = i_Start & ~start_prev;

    // State register plus every registered output. The status flags are
    // decoded from the next state so they line up with o_State on the
    // same clock.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            lives       <= LIVES_INI;
            level       <= 4'd0;
            frog_reset  <= 1'b0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            start_prev  <= 1'b1;
        end else begin
            state       <= next_state;
            lives       <= next_lives;
            level       <= next_level;
            frog_reset  <= next_frog_reset;
            game_active <= (next_state == ST_RUNNING);
            game_over   <= (next_state == ST_GAME_OVER);
            win         <= (next_state == ST_WIN);
            start_prev  <= i_Start;
        end
    end

    // Next-state logic. A collision outranks a level-up in the same cycle,
    // so that level-up is simply lost. The collision that takes the last
    // life goes straight to GAME_OVER without a recovery window, but the
    // frog is still sent home so the board looks sane on the final screen.
    // During HIT both collision and level-up are ignored, which is why a
    // long overlap only ever costs a single life.
    always_comb begin
        next_state      = state;
        next_lives      = lives;
        next_level      = level;
        next_frog_reset = 1'b0;
        timer_load      = 1'b0;

        case (state)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (start_event) begin
                    next_state      = ST_RUNNING;
                    next_lives      = LIVES_INI;
                    next_level      = 4'd0;
                    next_frog_reset = 1'b1;
                end
            end

            ST_RUNNING: begin
                if (i_Has_Collided) begin
                    next_frog_reset = 1'b1;
                    if (lives <= 2'd1) begin
                        next_lives = 2'd0;
                        next_state = ST_GAME_OVER;
                    end else begin
                        next_lives = lives - 2'd1;
                        next_state = ST_HIT;
                        timer_load = 1'b1;
                    end
                end else if (i_Level_Up) begin
                    next_level = level_inc_sat(level);
                    if (i_Score >= WIN_SCORE) begin
                        next_state = ST_WIN;
                    end
                end
            end

            ST_HIT: begin
                if (timer_done) begin
                    next_state = ST_RUNNING;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // The timer only keeps running while HIT persists; on the exit cycle
    // it drops to idle, which also forces the flash output low.
    assign timer_run = (state == ST_HIT) && (next_state == ST_HIT);

    frogger_game_flow_timer #(
        .C_COUNT_BITS   (TIMER_BITS),
        .C_BLINK_CYCLES (C_BLINK_CYCLES)
    ) u_hit_timer (
        .clk        (i_Clk),
        .reset      (i_Reset),
        .load       (timer_load),
        .load_value (HIT_LOAD),
        .run        (timer_run),
        .done       (timer_done),
        .flash      (flash)
    );

    assign o_State       = state;
    assign o_Lives       = lives;
    assign o_Level       = level;
    assign o_Frog_Reset  = frog_reset;
    assign o_Game_Active = game_active;
    assign o_Game_Over   = game_over;
    assign o_Win         = win;
    assign o_Flash       = flash;

endmodule
